match_window_counter: RTL
=========================

MATCH_WINDOW_COUNTER -- requirements
Module: match_window_counter

Interface
REQ-001 Parameter: CNT_BITS, default 4, width of the match count and result.
REQ-002 Parameter: WIN_BITS, default 4, width of the window length and bit position.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: bit_valid  in  1  high for exactly the cycles in which a new serial bit is applied to the upstream 1101 detector.
REQ-006 Port: match  in  1  Mealy detector output o; qualified by bit_valid.
REQ-007 Port: clear  in  1  synchronous clear of all counting state.
REQ-008 Port: window_len  in  WIN_BITS  bits per window; the value 0 means 2^WIN_BITS.
REQ-009 Port: result_ack  in  1  consumer acknowledge of result.
REQ-010 Port: result  out  CNT_BITS  match count of the last completed window.
REQ-011 Port: result_valid  out  1  result holds an unacknowledged value.
REQ-012 Port: overrun  out  1  sticky flag: an unacknowledged result was overwritten.
REQ-013 Port: bit_pos  out  WIN_BITS  number of bits accepted so far in the current window.

Function
REQ-014 match shall be sampled only on rising edges where bit_valid=1; match with bit_valid=0 shall be ignored.
REQ-015 On a qualified edge: bit_pos shall increment by 1, and if match=1 the internal match_cnt shall increment by 1.
REQ-016 match_cnt shall saturate at 2^CNT_BITS-1 and shall never wrap.
REQ-017 Window completion shall occur on a qualified edge where bit_pos >= eff_len-1 (unsigned), with eff_len = window_len, or 2^WIN_BITS when window_len=0.
REQ-018 Use of >= shall ensure completion on the next qualified bit when window_len is reduced mid-window below bit_pos.
REQ-019 On completion: result <= saturating(match_cnt + match), result_valid <= 1, bit_pos <= 0, match_cnt <= 0, all on the same edge.
REQ-020 Latency: result and result_valid shall be valid one edge after the completing bit is sampled; there is no bubble, and the next window's first bit is accepted on the following qualified edge.
REQ-021 Handshake: result_valid shall remain 1, with result stable, until an edge with result_ack=1; result_valid shall then be 0 after that edge unless a completion also occurs on it.
REQ-022 result_ack with result_valid=0 shall have no effect.
REQ-023 Completion with result_ack=1 on the same edge shall load the new result, keep result_valid=1, and leave overrun unchanged.
REQ-024 Completion with result_valid=1 and result_ack=0 shall overwrite result with the new count and set overrun=1.
REQ-025 overrun shall stay set until clear or rst.
REQ-026 clear=1 shall zero bit_pos, match_cnt, result, result_valid and overrun on the edge, with priority over bit_valid, completion and result_ack.
REQ-027 All outputs shall be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 shall immediately, without waiting for clk, force result=0, result_valid=0, overrun=0, bit_pos=0 and match_cnt=0.
REQ-029 These values shall hold while rst=1 regardless of other inputs.
REQ-030 The first qualified bit after rst deasserts shall count as bit 0 of a new window.
REQ-031 rst asserted mid-window shall discard the partial window, and any pending result shall be lost with no overrun.

Verification
REQ-032 Async reset: assert rst mid-clock-phase with bit_pos=3 and result_valid=1 -> all outputs 0 before the next clk edge, held across 2 clock cycles.
REQ-033 Basic window: window_len=4, bits 1,1,0,1 with match 0,0,0,1 -> after the 4th edge result=1, result_valid=1, bit_pos=0; ack one cycle -> result_valid=0.
REQ-034 Overlap: window_len=7, bits 1,1,0,1,1,0,1 with match 0,0,0,1,0,0,1 -> result=2; bit_valid gaps of 2 idle cycles between bits with match=1 during the gaps -> still result=2.
REQ-035 Saturation/wrap: window_len=0 (16 bits), match=1 on every bit -> result=15, completion on the 16th bit, bit_pos returns 0.
REQ-036 Overrun: window_len=2, two windows with no ack -> overrun=1, result = second count; repeat after clear with ack on the completion edge -> overrun=0, result_valid=1.
REQ-037 Clear/shrink: clear on an edge coinciding with a completion and ack -> all zero; window_len changed 8->2 at bit_pos=5 -> completes on the next qualified bit.

Source files
------------

// File: rtl/match_window_counter.sv
// match_window_counter: counts qualified 1101-detector matches over windows of
// window_len serial bits and hands each window's count to a consumer through a
// valid/ack handshake. A result that is still unacknowledged when it is
// overwritten raises a sticky overrun flag.
module match_window_counter #(
  parameter int unsigned CNT_BITS = 4,
  parameter int unsigned WIN_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_valid,
  input  logic                match,
  input  logic                clear,
  input  logic [WIN_BITS-1:0] window_len,
  input  logic                result_ack,
  output logic [CNT_BITS-1:0] result,
  output logic                result_valid,
  output logic                overrun,
  output logic [WIN_BITS-1:0] bit_pos
);

  // One extra bit so that window_len=0 can represent 2^WIN_BITS
  localparam int unsigned LEN_W = WIN_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0] r_match_cnt;
  logic [CNT_BITS-1:0] r_result;
  logic                r_result_valid;
  logic                r_overrun;
  logic [WIN_BITS-1:0] r_bit_pos;

  logic [LEN_W-1:0]    w_eff_len;
  logic [LEN_W-1:0]    w_last_pos;
  logic                w_last_bit;
  logic                w_complete;
  logic [CNT_BITS-1:0] w_cnt_next;

  // Effective window length and the position of its last bit
  assign w_eff_len  = (window_len == '0) ? {1'b1, {WIN_BITS{1'b0}}}
                                         : {1'b0, window_len};
  assign w_last_pos = w_eff_len - LEN_W'(1);

  // >= so a window shrunk below the current position completes on the next bit
  assign w_last_bit = ({1'b0, r_bit_pos} >= w_last_pos);
  assign w_complete = bit_valid & w_last_bit;

  // Saturating count including the bit sampled on this edge
  assign w_cnt_next = (match && (r_match_cnt != CNT_MAX))
                      ? r_match_cnt + CNT_BITS'(1) : r_match_cnt;

  // Window counting, result handshake and overrun tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_cnt    <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_bit_pos      <= '0;
    end else if (clear) begin
      r_match_cnt    <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_bit_pos      <= '0;
    end else begin
      if (bit_valid) begin
        if (w_last_bit) begin
          r_match_cnt <= '0;
          r_bit_pos   <= '0;
        end else begin
          r_match_cnt <= w_cnt_next;
          r_bit_pos   <= r_bit_pos + WIN_BITS'(1);
        end
      end

      if (w_complete) begin
        r_result       <= w_cnt_next;
        r_result_valid <= 1'b1;
        if (r_result_valid && !result_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (result_ack) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overrun      = r_overrun;
  assign bit_pos      = r_bit_pos;

endmodule
